// File: rtl/vdma_axi4_to_axi4s_burst_pkg.sv
// vdma_axi4_to_axi4s_burst_pkg: AXI constants, state encodings and sizing helper
// shared by the video-DMA read core and its burst generator.
package vdma_axi4_to_axi4s_burst_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUFMOD = 4'b0011;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/vdma_axi4_ar_gen.sv
// vdma_axi4_ar_gen: AR burst/address generator walking a 2-D frame line by line,
// shortening the final burst of each line.
module vdma_axi4_ar_gen
    import vdma_axi4_to_axi4s_burst_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_SIZE  = 2,
    parameter int AXI4_LEN_WIDTH  = 8,
    parameter int STRIDE_WIDTH    = 14,
    parameter int H_WIDTH         = 12,
    parameter int V_WIDTH         = 12
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       start,
    input  logic                       full_next,
    input  logic [AXI4_ADDR_WIDTH-1:0] param_addr,
    input  logic [STRIDE_WIDTH-1:0]    param_stride,
    input  logic [H_WIDTH-1:0]         param_width,
    input  logic [V_WIDTH-1:0]         param_height,
    input  logic [AXI4_LEN_WIDTH-1:0]  param_arlen,
    input  logic                       arready,
    output logic [AXI4_ADDR_WIDTH-1:0] araddr,
    output logic [AXI4_LEN_WIDTH-1:0]  arlen,
    output logic                       arvalid,
    output logic                       ar_hs,
    output logic                       last_hs
);
    localparam int CW = max_int(H_WIDTH, AXI4_LEN_WIDTH) + 1;
    logic [AXI4_ADDR_WIDTH-1:0] line_base, next_line, step;
    logic [STRIDE_WIDTH-1:0]    stride_r;
    logic [H_WIDTH-1:0]         width_r, px_r;
    logic [V_WIDTH-1:0]         lines_r;
    logic [AXI4_LEN_WIDTH-1:0]  arlen_max;
    logic [CW-1:0]              px_left, need, cap;
    logic                       active, line_end;
    // px_r holds the pixels left in the line including the burst currently presented
    assign px_left   = CW'(px_r) - CW'(arlen) - CW'(1);
    assign line_end  = px_left == '0;
    assign next_line = line_base + AXI4_ADDR_WIDTH'(stride_r);
    assign step      = (AXI4_ADDR_WIDTH'(arlen) + AXI4_ADDR_WIDTH'(1)) << AXI4_DATA_SIZE;
    assign need      = (start ? CW'(param_width) : line_end ? CW'(width_r) : px_left) - CW'(1);
    assign cap       = start ? CW'(param_arlen) : CW'(arlen_max);
    assign ar_hs     = arvalid && arready;
    assign last_hs   = ar_hs && line_end && lines_r == V_WIDTH'(1);
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            araddr    <= '0;
            arlen     <= '0;
            arvalid   <= 1'b0;
            active    <= 1'b0;
            line_base <= '0;
            stride_r  <= '0;
            width_r   <= '0;
            px_r      <= '0;
            lines_r   <= '0;
            arlen_max <= '0;
        end else if (start) begin
            araddr    <= param_addr;
            line_base <= param_addr;
            arlen     <= AXI4_LEN_WIDTH'((need < cap) ? need : cap);
            arvalid   <= !full_next;
            active    <= 1'b1;
            stride_r  <= param_stride;
            width_r   <= param_width;
            px_r      <= param_width;
            lines_r   <= param_height;
            arlen_max <= param_arlen;
        end else begin
            if (ar_hs) begin
                arlen     <= AXI4_LEN_WIDTH'((need < cap) ? need : cap);
                araddr    <= line_end ? next_line : araddr + step;
                line_base <= line_end ? next_line : line_base;
                px_r      <= line_end ? width_r : H_WIDTH'(px_left);
                lines_r   <= line_end ? lines_r - V_WIDTH'(1) : lines_r;
            end
            active  <= active && !last_hs;
            arvalid <= active && !last_hs && ((arvalid && !ar_hs) || !full_next);
        end
    end
endmodule

// File: rtl/vdma_axi4_to_axi4s_burst.sv
// vdma_axi4_to_axi4s_burst: frame fetch over AXI4 read, emitted as AXI4-Stream video
// with tuser at frame start and tlast at line end.
module vdma_axi4_to_axi4s_burst
    import vdma_axi4_to_axi4s_burst_pkg::*;
#(
    parameter int AXI4_ID_WIDTH    = 6,
    parameter int AXI4_ADDR_WIDTH  = 32,
    parameter int AXI4_DATA_SIZE   = 2,
    parameter int AXI4_LEN_WIDTH   = 8,
    parameter int AXI4S_DATA_WIDTH = 24,
    parameter int STRIDE_WIDTH     = 14,
    parameter int H_WIDTH          = 12,
    parameter int V_WIDTH          = 12,
    parameter int INDEX_WIDTH      = 8,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              ctl_enable,
    input  logic                              ctl_oneshot,
    output logic                              busy,
    input  logic [AXI4_ADDR_WIDTH-1:0]        param_addr,
    input  logic [STRIDE_WIDTH-1:0]           param_stride,
    input  logic [H_WIDTH-1:0]                param_width,
    input  logic [V_WIDTH-1:0]                param_height,
    input  logic [AXI4_LEN_WIDTH-1:0]         param_arlen,
    output logic [INDEX_WIDTH-1:0]            status_index,
    output logic                              status_frame_done,
    output logic                              status_rerr,
    output logic [AXI4_ID_WIDTH-1:0]          m_axi4_arid,
    output logic [AXI4_ADDR_WIDTH-1:0]        m_axi4_araddr,
    output logic [AXI4_LEN_WIDTH-1:0]         m_axi4_arlen,
    output logic [2:0]                        m_axi4_arsize,
    output logic [1:0]                        m_axi4_arburst,
    output logic                              m_axi4_arlock,
    output logic [3:0]                        m_axi4_arcache,
    output logic [2:0]                        m_axi4_arprot,
    output logic [3:0]                        m_axi4_arqos,
    output logic [3:0]                        m_axi4_arregion,
    output logic                              m_axi4_arvalid,
    input  logic                              m_axi4_arready,
    input  logic [AXI4_ID_WIDTH-1:0]          m_axi4_rid,
    input  logic [1:0]                        m_axi4_rresp,
    input  logic [(8<<AXI4_DATA_SIZE)-1:0]    m_axi4_rdata,
    input  logic                              m_axi4_rlast,
    input  logic                              m_axi4_rvalid,
    output logic                              m_axi4_rready,
    output logic                              m_axi4s_tuser,
    output logic                              m_axi4s_tlast,
    output logic [AXI4S_DATA_WIDTH-1:0]       m_axi4s_tdata,
    output logic                              m_axi4s_tvalid,
    input  logic                              m_axi4s_tready
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    logic [1:0]         state;
    logic [H_WIDTH-1:0] width_r, h_cnt;
    logic [V_WIDTH-1:0] height_r, v_cnt;
    logic [OW-1:0]      out_cnt, out_next;
    logic               beat, line_last, frame_end, latch, ar_hs, last_hs, full_next, unused_ok;
    assign busy      = state != ST_IDLE;
    assign beat      = m_axi4_rvalid && m_axi4s_tready;
    assign line_last = h_cnt == width_r - H_WIDTH'(1);
    assign frame_end = busy && beat && line_last && v_cnt == height_r - V_WIDTH'(1);
    // a frame end with continuous mode re-latches in the same cycle so AR restarts immediately
    assign latch     = ctl_enable && |param_width && |param_height &&
                       (state == ST_IDLE || (frame_end && !ctl_oneshot));
    assign out_next  = out_cnt + OW'(ar_hs) - OW'(beat && m_axi4_rlast);
    assign full_next = out_next == OW'(MAX_OUTSTANDING);
    assign m_axi4_arid     = '0;
    assign m_axi4_arsize   = 3'(AXI4_DATA_SIZE);
    assign m_axi4_arburst  = AXI_BURST_INCR;
    assign m_axi4_arlock   = 1'b0;
    assign m_axi4_arcache  = AXI_CACHE_BUFMOD;
    assign m_axi4_arprot   = '0;
    assign m_axi4_arqos    = '0;
    assign m_axi4_arregion = '0;
    assign m_axi4_rready   = m_axi4s_tready;
    assign m_axi4s_tvalid  = m_axi4_rvalid;
    assign m_axi4s_tdata   = m_axi4_rdata[AXI4S_DATA_WIDTH-1:0];
    assign m_axi4s_tuser   = busy && h_cnt == '0 && v_cnt == '0;
    assign m_axi4s_tlast   = busy && line_last;
    assign unused_ok       = ^{m_axi4_rid, m_axi4_rdata};
    vdma_axi4_ar_gen #(
        .AXI4_ADDR_WIDTH(AXI4_ADDR_WIDTH),
        .AXI4_DATA_SIZE (AXI4_DATA_SIZE),
        .AXI4_LEN_WIDTH (AXI4_LEN_WIDTH),
        .STRIDE_WIDTH   (STRIDE_WIDTH),
        .H_WIDTH        (H_WIDTH),
        .V_WIDTH        (V_WIDTH)
    ) u_ar_gen (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (latch),
        .full_next   (full_next),
        .param_addr  (param_addr),
        .param_stride(param_stride),
        .param_width (param_width),
        .param_height(param_height),
        .param_arlen (param_arlen),
        .arready     (m_axi4_arready),
        .araddr      (m_axi4_araddr),
        .arlen       (m_axi4_arlen),
        .arvalid     (m_axi4_arvalid),
        .ar_hs       (ar_hs),
        .last_hs     (last_hs)
    );
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= ST_IDLE;
            width_r           <= '0;
            height_r          <= '0;
            h_cnt             <= '0;
            v_cnt             <= '0;
            out_cnt           <= '0;
            status_index      <= '0;
            status_rerr       <= 1'b0;
            status_frame_done <= 1'b0;
        end else begin
            state <= latch ? ST_RUN : frame_end ? ST_IDLE :
                     (state == ST_RUN && last_hs) ? ST_DRAIN : state;
            out_cnt           <= out_next;
            status_frame_done <= frame_end;
            if (latch) begin
                width_r      <= param_width;
                height_r     <= param_height;
                h_cnt        <= '0;
                v_cnt        <= '0;
                status_index <= status_index + INDEX_WIDTH'(1);
                status_rerr  <= 1'b0;
            end else begin
                status_rerr <= status_rerr || (beat && m_axi4_rresp != 2'b00);
                if (busy && beat) begin
                    h_cnt <= line_last ? '0 : h_cnt + H_WIDTH'(1);
                    v_cnt <= !line_last ? v_cnt : frame_end ? '0 : v_cnt + V_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vdma_axi4_to_axi4s_burst.sv
// tb_vdma_axi4_to_axi4s_burst: directed table-driven bench with a behavioural AXI4 read slave.
module tb_vdma_axi4_to_axi4s_burst;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ctl_enable = 1'b0, ctl_oneshot = 1'b1, busy;
    logic [31:0] param_addr = '0;
    logic [13:0] param_stride = '0;
    logic [11:0] param_width = '0, param_height = '0;
    logic [7:0]  param_arlen = '0, status_index;
    logic        status_frame_done, status_rerr;
    logic [5:0]  arid, rid = '0;
    logic [31:0] araddr, rdata = '0;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, rresp = '0;
    logic [3:0]  arcache, arqos, arregion;
    logic        arlock, arvalid, arready = 1'b1, rlast = 1'b0, rvalid = 1'b0, rready;
    logic        tuser, tlast, tvalid, tready = 1'b1;
    logic [23:0] tdata;

    always #5 clk = ~clk;

    vdma_axi4_to_axi4s_burst dut (
        .aclk(clk), .aresetn(aresetn), .ctl_enable(ctl_enable), .ctl_oneshot(ctl_oneshot), .busy(busy),
        .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
        .param_height(param_height), .param_arlen(param_arlen), .status_index(status_index),
        .status_frame_done(status_frame_done), .status_rerr(status_rerr),
        .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arlen(arlen), .m_axi4_arsize(arsize),
        .m_axi4_arburst(arburst), .m_axi4_arlock(arlock), .m_axi4_arcache(arcache), .m_axi4_arprot(arprot),
        .m_axi4_arqos(arqos), .m_axi4_arregion(arregion), .m_axi4_arvalid(arvalid), .m_axi4_arready(arready),
        .m_axi4_rid(rid), .m_axi4_rresp(rresp), .m_axi4_rdata(rdata), .m_axi4_rlast(rlast),
        .m_axi4_rvalid(rvalid), .m_axi4_rready(rready), .m_axi4s_tuser(tuser), .m_axi4s_tlast(tlast),
        .m_axi4s_tdata(tdata), .m_axi4s_tvalid(tvalid), .m_axi4s_tready(tready)
    );

    int errors = 0, checks = 0, cyc = 0;
    bit r_en = 1'b1, ar_rdy = 1'b1, tog = 1'b0, flush = 1'b0;
    int err_beat = -1, nbeats = 0, fd_cnt = 0, rr_bad = 0;
    logic [31:0] ar_a_log[$];
    int          ar_l_log[$], ar_c_log[$], bt_c_log[$];
    logic [25:0] bt_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // slave: logs handshakes at negedge, then drives the next cycle's R beat after the edge
    initial begin
        logic [31:0] qa[$];
        int ql[$];
        int rb = 0;
        bit arf, rf;
        forever begin
            @(negedge clk);
            arf = arvalid && arready;
            rf  = rvalid && rready;
            if (arf) begin ar_a_log.push_back(araddr); ar_l_log.push_back(int'(arlen)); ar_c_log.push_back(cyc); end
            if (rvalid && tready) begin bt_log.push_back({tuser, tlast, tdata}); bt_c_log.push_back(cyc); end
            if (rready !== tready) rr_bad++;
            if (status_frame_done) fd_cnt++;
            @(posedge clk); #1;
            if (flush) begin qa.delete(); ql.delete(); rb = 0; arf = 0; rf = 0; end
            if (arf) begin qa.push_back(ar_a_log[$]); ql.push_back(ar_l_log[$]); end
            if (rf && ql.size() > 0) begin
                nbeats++;
                if (rb == ql[0]) begin void'(qa.pop_front()); void'(ql.pop_front()); rb = 0; end
                else rb++;
            end
            rvalid  = r_en && ql.size() > 0;
            rdata   = (ql.size() > 0) ? qa[0] + 32'(rb * 4) : 32'h0;
            rlast   = ql.size() > 0 && rb == ql[0];
            rresp   = (rvalid && nbeats == err_beat) ? 2'b10 : 2'b00;
            tready  = tog ? !tready : 1'b1;
            arready = ar_rdy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic start_frame(input int w, input int h, input int len, input logic [31:0] a,
                               input logic [31:0] s, input bit oneshot);
        param_width = 12'(w); param_height = 12'(h); param_arlen = 8'(len);
        param_addr = a; param_stride = 14'(s); ctl_oneshot = oneshot; ctl_enable = 1'b1;
        tick();
        if (oneshot) ctl_enable = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int f0 = fd_cnt;
        int c = 0;
        while (fd_cnt == f0 && c < budget) begin @(posedge clk); c++; end
        #1;
        chk(nm, 64'(fd_cnt - f0), 64'd1);
    endtask

    task automatic pulse_reset();
        aresetn = 1'b0; flush = 1'b1;
        tick(2);
        aresetn = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    typedef struct { int w, h, len; logic [31:0] addr, stride; bit tog; int n_ar; } sc_t;
    typedef struct { int sc; logic [31:0] a; int l; } ar_t;

    initial begin
        sc_t sc_tab[4];
        ar_t ar_tab[21];
        int a0, b0, f0, k;
        logic [7:0] idx0;
        sc_tab = '{'{8, 2, 3, 32'h1000, 64, 0, 4}, '{10, 2, 3, 32'h2000, 64, 0, 6},
                   '{6, 3, 1, 32'h3000, 32'h100, 1, 9}, '{1, 2, 7, 32'h4000, 32'h20, 0, 2}};
        ar_tab = '{'{0, 32'h1000, 3}, '{0, 32'h1010, 3}, '{0, 32'h1040, 3}, '{0, 32'h1050, 3},
                   '{1, 32'h2000, 3}, '{1, 32'h2010, 3}, '{1, 32'h2020, 1},
                   '{1, 32'h2040, 3}, '{1, 32'h2050, 3}, '{1, 32'h2060, 1},
                   '{2, 32'h3000, 1}, '{2, 32'h3008, 1}, '{2, 32'h3010, 1},
                   '{2, 32'h3100, 1}, '{2, 32'h3108, 1}, '{2, 32'h3110, 1},
                   '{2, 32'h3200, 1}, '{2, 32'h3208, 1}, '{2, 32'h3210, 1},
                   '{3, 32'h4000, 0}, '{3, 32'h4020, 0}};
        tick(3);
        chk("rst_busy", busy, 0); chk("rst_arvalid", arvalid, 0); chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0); chk("rst_index", status_index, 0); chk("rst_rerr", status_rerr, 0);
        chk("rst_done", status_frame_done, 0); chk("rst_tuser", tuser, 0); chk("rst_tlast", tlast, 0);
        aresetn = 1'b1;
        tick(2);
        chk("arsize", arsize, 3'd2); chk("arburst", arburst, 2'b01); chk("arcache", arcache, 4'b0011);
        // zero width / height must not start a frame
        a0 = ar_a_log.size();
        start_frame(0, 2, 3, 32'h100, 64, 1);
        tick(3);
        start_frame(4, 0, 3, 32'h100, 64, 1);
        tick(3);
        chk("zero_busy", busy, 0); chk("zero_index", status_index, 0); chk("zero_ars", 64'(ar_a_log.size() - a0), 0);

        for (int s = 0; s < 4; s++) begin
            a0 = ar_a_log.size(); b0 = bt_log.size(); f0 = fd_cnt; idx0 = status_index;
            tog = sc_tab[s].tog;
            start_frame(sc_tab[s].w, sc_tab[s].h, sc_tab[s].len, sc_tab[s].addr, sc_tab[s].stride, 1);
            wait_done(2000, $sformatf("s%0d_done", s));
            tog = 1'b0;
            tick(3);
            chk($sformatf("s%0d_ar_count", s), 64'(ar_a_log.size() - a0), 64'(sc_tab[s].n_ar));
            k = 0;
            for (int j = 0; j < 21; j++) if (ar_tab[j].sc == s) begin
                chk($sformatf("s%0d_araddr%0d", s, k), ar_a_log[a0 + k], ar_tab[j].a);
                chk($sformatf("s%0d_arlen%0d", s, k), 64'(ar_l_log[a0 + k]), 64'(ar_tab[j].l));
                k++;
            end
            chk($sformatf("s%0d_beats", s), 64'(bt_log.size() - b0), 64'(sc_tab[s].w * sc_tab[s].h));
            for (int i = 0; i < sc_tab[s].w * sc_tab[s].h; i++) begin
                logic [25:0] e;
                e = {i == 0, (i % sc_tab[s].w) == sc_tab[s].w - 1,
                     24'(sc_tab[s].addr + (i / sc_tab[s].w) * sc_tab[s].stride + (i % sc_tab[s].w) * 4)};
                chk($sformatf("s%0d_beat%0d{tuser,tlast,tdata}", s, i), bt_log[b0 + i], e);
            end
            chk($sformatf("s%0d_index", s), status_index, 64'(idx0 + 8'd1));
            chk($sformatf("s%0d_busy", s), busy, 0);
            chk($sformatf("s%0d_done_pulses", s), 64'(fd_cnt - f0), 1);
        end

        // outstanding limit: no R data, so only MAX_OUTSTANDING bursts may be issued
        a0 = ar_a_log.size(); b0 = bt_log.size();
        r_en = 1'b0;
        start_frame(64, 1, 3, 32'h8000, 0, 1);
        tick(10);
        chk("gate_ar_count", 64'(ar_a_log.size() - a0), 4);
        @(negedge clk);
        chk("gate_arvalid", arvalid, 0);
        tick();
        r_en = 1'b1;
        tick(2);
        chk("gate_ar_count_hold", 64'(ar_a_log.size() - a0), 4);
        wait_done(2000, "gate_done");
        tick(2);
        chk("gate_ar_total", 64'(ar_a_log.size() - a0), 16);
        chk("gate_beats", 64'(bt_log.size() - b0), 64);
        chk("gate_release_cycle", 64'(ar_c_log[a0 + 4]), 64'(bt_c_log[b0 + 3] + 1));

        // continuous mode
        pulse_reset();
        a0 = ar_a_log.size(); b0 = bt_log.size();
        start_frame(4, 1, 3, 32'h5000, 64, 0);
        chk("cont_index1", status_index, 1);
        wait_done(200, "cont_done1");
        chk("cont_index2", status_index, 2);
        ctl_enable = 1'b0;
        wait_done(200, "cont_done2");
        tick(3);
        chk("cont_busy", busy, 0);
        chk("cont_index_final", status_index, 2);
        chk("cont_ar_count", 64'(ar_a_log.size() - a0), 2);
        chk("cont_restart_cycle", 64'(ar_c_log[a0 + 1]), 64'(bt_c_log[b0 + 3] + 1));
        chk("cont_tuser2", bt_log[b0 + 4][25], 1);

        // read error is sticky until the next latch, then async reset mid-frame
        err_beat = nbeats + 2;
        start_frame(4, 2, 3, 32'h6000, 64, 1);
        wait_done(200, "rerr_done");
        err_beat = -1;
        chk("rerr_set", status_rerr, 1);
        tick(3);
        chk("rerr_sticky", status_rerr, 1);
        start_frame(8, 2, 3, 32'h7000, 64, 1);
        @(negedge clk);
        chk("rerr_clear", status_rerr, 0);
        tick(3);
        chk("mid_busy", busy, 1);
        #2;
        aresetn = 1'b0; flush = 1'b1;
        #1;
        chk("arst_busy", busy, 0); chk("arst_arvalid", arvalid, 0); chk("arst_araddr", araddr, 0);
        chk("arst_arlen", arlen, 0); chk("arst_index", status_index, 0); chk("arst_rerr", status_rerr, 0);
        chk("arst_done", status_frame_done, 0); chk("arst_tuser", tuser, 0); chk("arst_tlast", tlast, 0);
        tick(2);
        aresetn = 1'b1;
        tick(2);
        flush = 1'b0;
        tick(2);
        chk("rready_mirror", 64'(rr_bad), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
